// File: rtl/instr_mem_fetch_if.sv
// Fetch-side bus of the instruction memory: request, response, flush and program load.
// The master is the PC/fetch stage; the slave is instr_mem_fetch.
interface instr_mem_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_pc;
  logic              flush;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_pc;
  logic [WORD_W-1:0] rsp_instr;
  logic [1:0]        rsp_fault;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [WORD_W-1:0] ld_data;

  modport master (
    output req_valid, req_pc, flush, rsp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_pc, rsp_instr, rsp_fault
  );

  modport slave (
    input  req_valid, req_pc, flush, rsp_ready, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_pc, rsp_instr, rsp_fault
  );
endinterface

// File: rtl/instr_mem_fetch.sv
// Synchronous-read instruction memory with a LATENCY-deep valid/ready fetch pipeline,
// flush on redirect, a program-load write port and alignment/range fault reporting.
module instr_mem_fetch #(
  parameter int                ADDR_W   = 8,
  parameter int                WORD_W   = 32,
  parameter int                LATENCY  = 1,
  parameter logic [WORD_W-1:0] NOP_WORD = '0
) (
  input logic              clk,
  input logic              rst_n,
  instr_mem_fetch_if.slave fif
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [WORD_W-1:0] instr;
    logic [1:0]        fault;
  } stage_t;

  logic [WORD_W-1:0] mem [DEPTH];

  stage_t            stage_q [LATENCY];
  stage_t            stage_d [LATENCY];
  logic              stall;
  logic              accept;
  logic [1:0]        req_fault;
  logic [ADDR_W-1:0] req_idx;

  // A response waiting on the decode stage freezes the whole pipe.
  assign stall         = stage_q[LATENCY-1].valid && !fif.rsp_ready;
  assign fif.req_ready = !stall && !fif.ld_en && !fif.flush;
  assign accept        = fif.req_valid && fif.req_ready;

  assign req_idx   = fif.req_pc[ADDR_W+1:2];
  assign req_fault = {|fif.req_pc[31:ADDR_W+2], |fif.req_pc[1:0]};

  // NOTE: the array has no reset; its contents come only from program loads and
  // survive rst_n, which also lets synthesis map it onto block RAM.
  always_ff @(posedge clk) begin
    if (fif.ld_en) begin
      mem[fif.ld_addr] <= fif.ld_data;
    end
  end

  // NOTE: stage_d takes its hold value before any branch, so every path assigns it
  // and no latch is inferred.
  always_comb begin
    stage_d = stage_q;
    if (fif.flush) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_d[i].valid = 1'b0;
      end
    end else if (!stall) begin
      stage_d[0].valid = accept;
      if (accept) begin
        stage_d[0].pc    = fif.req_pc;
        stage_d[0].fault = req_fault;
        stage_d[0].instr = (req_fault != 2'b00) ? NOP_WORD : mem[req_idx];
      end
      for (int i = 1; i < LATENCY; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every stage samples the
  // pre-edge value of its predecessor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign fif.rsp_valid = stage_q[LATENCY-1].valid;
  assign fif.rsp_pc    = stage_q[LATENCY-1].pc;
  assign fif.rsp_instr = stage_q[LATENCY-1].instr;
  assign fif.rsp_fault = stage_q[LATENCY-1].fault;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Scoreboard bench: three instances (LATENCY 1, 2, 3) share stimulus; sel picks which
// one sees requests and drives the observed outputs, while loads reach all of them.
module tb_instr_mem_fetch;

  logic        clk;
  logic        rst_n;
  int          sel;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        flush;
  logic        rsp_ready;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  logic        m_req_ready;
  logic        m_rsp_valid;
  logic [31:0] m_rsp_pc;
  logic [31:0] m_rsp_instr;
  logic [1:0]  m_rsp_fault;

  int n_checks = 0;
  int n_errors = 0;
  int n_rsp    = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  fault;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] ref_mem [256];

  instr_mem_fetch_if #(.ADDR_W(8), .WORD_W(32)) if1 ();
  instr_mem_fetch_if #(.ADDR_W(8), .WORD_W(32)) if2 ();
  instr_mem_fetch_if #(.ADDR_W(8), .WORD_W(32)) if3 ();

  instr_mem_fetch #(.ADDR_W(8), .WORD_W(32), .LATENCY(1), .NOP_WORD(32'h0))
    u_lat1 (.clk(clk), .rst_n(rst_n), .fif(if1));
  instr_mem_fetch #(.ADDR_W(8), .WORD_W(32), .LATENCY(2), .NOP_WORD(32'h0))
    u_lat2 (.clk(clk), .rst_n(rst_n), .fif(if2));
  instr_mem_fetch #(.ADDR_W(8), .WORD_W(32), .LATENCY(3), .NOP_WORD(32'h0))
    u_lat3 (.clk(clk), .rst_n(rst_n), .fif(if3));

  assign if1.req_valid = req_valid && (sel == 0);
  assign if1.rsp_ready = rsp_ready || (sel != 0);
  assign if1.req_pc    = req_pc;
  assign if1.flush     = flush;
  assign if1.ld_en     = ld_en;
  assign if1.ld_addr   = ld_addr;
  assign if1.ld_data   = ld_data;

  assign if2.req_valid = req_valid && (sel == 1);
  assign if2.rsp_ready = rsp_ready || (sel != 1);
  assign if2.req_pc    = req_pc;
  assign if2.flush     = flush;
  assign if2.ld_en     = ld_en;
  assign if2.ld_addr   = ld_addr;
  assign if2.ld_data   = ld_data;

  assign if3.req_valid = req_valid && (sel == 2);
  assign if3.rsp_ready = rsp_ready || (sel != 2);
  assign if3.req_pc    = req_pc;
  assign if3.flush     = flush;
  assign if3.ld_en     = ld_en;
  assign if3.ld_addr   = ld_addr;
  assign if3.ld_data   = ld_data;

  always_comb begin
    case (sel)
      0: begin
        m_req_ready = if1.req_ready; m_rsp_valid = if1.rsp_valid; m_rsp_pc = if1.rsp_pc;
        m_rsp_instr = if1.rsp_instr; m_rsp_fault = if1.rsp_fault;
      end
      1: begin
        m_req_ready = if2.req_ready; m_rsp_valid = if2.rsp_valid; m_rsp_pc = if2.rsp_pc;
        m_rsp_instr = if2.rsp_instr; m_rsp_fault = if2.rsp_fault;
      end
      default: begin
        m_req_ready = if3.req_ready; m_rsp_valid = if3.rsp_valid; m_rsp_pc = if3.rsp_pc;
        m_rsp_instr = if3.rsp_instr; m_rsp_fault = if3.rsp_fault;
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] fault_of(input logic [31:0] pc);
    return {|pc[31:10], |pc[1:0]};
  endfunction

  // Inputs settle 1 time unit after posedge; the monitor samples them at negedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (flush) begin
        sb.delete();
      end else if (m_rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", m_rsp_pc, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_pc", m_rsp_pc, e.pc);
          check("rsp_instr", m_rsp_instr, e.instr);
          check("rsp_fault", {30'd0, m_rsp_fault}, {30'd0, e.fault});
        end
        n_rsp++;
      end
      if (req_valid && m_req_ready) begin
        exp_t e;
        e.pc    = req_pc;
        e.fault = fault_of(req_pc);
        e.instr = (e.fault != 2'b00) ? 32'h0 : ref_mem[req_pc[9:2]];
        sb.push_back(e);
      end
      if (ld_en) ref_mem[ld_addr] = ld_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] addr, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    @(negedge clk);
    check("ld_blocks_req", {31'd0, m_req_ready}, 32'd0);
    step();
    ld_en = 1'b0;
  endtask

  // Holds req_valid until the selected instance accepts, then returns 1 after that edge.
  task automatic request(input logic [31:0] pc);
    int waited = 0;
    req_valid = 1'b1;
    req_pc    = pc;
    @(negedge clk);
    while (!m_req_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!m_req_ready) check("req_accept_timeout", 32'd0, 32'd1);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int base;
    rst_n = 1'b0; sel = 0; req_valid = 1'b0; req_pc = '0; flush = 1'b0;
    rsp_ready = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    #3;
    check("rst_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    check("rst_rsp_pc", m_rsp_pc, 32'd0);
    check("rst_rsp_instr", m_rsp_instr, 32'd0);
    check("rst_rsp_fault", {30'd0, m_rsp_fault}, 32'd0);
    #9 rst_n = 1'b1;
    step();
    check("idle_req_ready", {31'd0, m_req_ready}, 32'd1);

    do_load(8'd0,   32'h8C02_0000);
    do_load(8'd1,   32'h0000_1820);
    do_load(8'd2,   32'h2002_000A);
    do_load(8'd255, 32'h03E0_0008);

    // LATENCY=1: response visible right after the accepting edge.
    sel = 0;
    request(32'h0);
    check("l1_rsp_valid", {31'd0, m_rsp_valid}, 32'd1);
    check("l1_rsp_instr", m_rsp_instr, 32'h8C02_0000);
    req_valid = 1'b0;
    step();
    check("l1_drained", {31'd0, m_rsp_valid}, 32'd0);

    // Fault reporting and the top legal word.
    request(32'h402);
    check("fault_both", {30'd0, m_rsp_fault}, 32'd3);
    check("fault_nop", m_rsp_instr, 32'h0);
    request(32'h3FC);
    check("last_word_fault", {30'd0, m_rsp_fault}, 32'd0);
    check("last_word_instr", m_rsp_instr, 32'h03E0_0008);
    req_valid = 1'b0;
    step();

    // LATENCY=3 back-to-back: three responses on consecutive cycles.
    sel  = 2;
    base = n_rsp;
    request(32'h0);
    check("l3_wait0", {31'd0, m_rsp_valid}, 32'd0);
    request(32'h4);
    check("l3_wait1", {31'd0, m_rsp_valid}, 32'd0);
    request(32'h8);
    check("l3_first", {31'd0, m_rsp_valid}, 32'd1);
    req_valid = 1'b0;
    step();
    check("l3_second", {31'd0, m_rsp_valid}, 32'd1);
    step();
    check("l3_third", {31'd0, m_rsp_valid}, 32'd1);
    step();
    check("l3_done", {31'd0, m_rsp_valid}, 32'd0);
    check("l3_count", n_rsp - base, 32'd3);

    // Back-pressure: two in flight, output held for 4 cycles.
    rsp_ready = 1'b0;
    request(32'h0);
    request(32'h4);
    req_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      check("stall_req_ready", {31'd0, m_req_ready}, 32'd0);
      check("stall_valid", {31'd0, m_rsp_valid}, 32'd1);
      check("stall_pc", m_rsp_pc, 32'h0);
      step();
    end
    rsp_ready = 1'b1;
    base = n_rsp;
    repeat (4) step();
    check("stall_count", n_rsp - base, 32'd2);
    check("stall_drained", {31'd0, m_rsp_valid}, 32'd0);

    // A load behind an in-flight fetch must not change what that fetch returns.
    request(32'h8);
    req_valid = 1'b0;
    do_load(8'd2, 32'hDEAD_BEEF);
    repeat (3) step();

    // LATENCY=2 flush while the output is stalled.
    sel       = 1;
    rsp_ready = 1'b0;
    request(32'h0);
    request(32'h4);
    req_valid = 1'b0;
    flush     = 1'b1;
    @(negedge clk);
    check("flush_req_ready", {31'd0, m_req_ready}, 32'd0);
    step();
    flush = 1'b0;
    check("flush_cleared", {31'd0, m_rsp_valid}, 32'd0);
    rsp_ready = 1'b1;
    base = n_rsp;
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_quiet", {31'd0, m_rsp_valid}, 32'd0);
    end
    check("flush_count", n_rsp - base, 32'd0);
    request(32'h4);
    req_valid = 1'b0;
    check("l2_wait", {31'd0, m_rsp_valid}, 32'd0);
    step();
    check("l2_after_flush", m_rsp_instr, 32'h0000_1820);
    step();

    // Asynchronous reset mid-burst, memory retained across it.
    sel = 2;
    request(32'h0);
    request(32'h4);
    request(32'h8);
    req_valid = 1'b0;
    check("pre_reset_valid", {31'd0, m_rsp_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_valid", {31'd0, m_rsp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    sel = 0;
    request(32'h4);
    req_valid = 1'b0;
    check("post_reset_instr", m_rsp_instr, 32'h0000_1820);
    step();
    step();

    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
